inst_mem_loader: RTL and testbench

Writes a stream of 32-bit instruction words into the byte-wide instruction memory, one byte per cycle, little-endian, at auto-incrementing addresses. Sits between the program source (testbench, boot ROM, or debug port) and the write side of the instruction memory array, so that the fetch side later reads each word back as {b[addr+3], b[addr+2], b[addr+1], b[addr]}. Handles handshake, byte sequencing, bounds checking, and end-of-program signalling.

---
 rtl/inst_mem_loader_if.sv | 40 ++++
 rtl/inst_mem_loader.sv | 171 +++++++++++++++++
 tb/tb_inst_mem_loader.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/inst_mem_loader_if.sv
// Word-stream and memory-write bundle for inst_mem_loader.
// The checksum signal exists only when INST_MEM_LOADER_CHECKSUM_EN is defined.
interface inst_mem_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  start;
  logic [31:0]           word_in;
  logic                  word_valid;
  logic                  word_last;
  logic                  word_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [7:0]            mem_wdata;
  logic                  busy;
  logic                  done;
  logic                  err;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
  logic [7:0]            checksum;

  modport master (
    output start, word_in, word_valid, word_last,
    input  word_ready, mem_we, mem_addr, mem_wdata, busy, done, err, checksum
  );

  modport slave (
    input  start, word_in, word_valid, word_last,
    output word_ready, mem_we, mem_addr, mem_wdata, busy, done, err, checksum
  );
`else
  modport master (
    output start, word_in, word_valid, word_last,
    input  word_ready, mem_we, mem_addr, mem_wdata, busy, done, err
  );

  modport slave (
    input  start, word_in, word_valid, word_last,
    output word_ready, mem_we, mem_addr, mem_wdata, busy, done, err
  );
`endif
endinterface

// File: rtl/inst_mem_loader.sv
// Streams 32-bit instruction words into byte-wide instruction memory, little-endian, with
// bounds checking. Define INST_MEM_LOADER_CHECKSUM_EN for a per-session 8-bit byte checksum.
module inst_mem_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 32,
  parameter int BASE_ADDR  = 0
) (
  input  logic              clk,
  input  logic              rst,
  inst_mem_loader_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_WRITE  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] BASE_PTR  = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0]   LAST_BYTE = (ADDR_WIDTH+1)'(DEPTH - 1);

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      2'd3:    b = w[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  state_t                state_r, state_s;
  logic [ADDR_WIDTH-1:0] ptr_r, ptr_s;
  logic [1:0]            bc_r, bc_s;
  logic [31:0]           word_r, word_s;
  logic                  last_r, last_s;
  logic                  err_r, err_s;
  logic [ADDR_WIDTH:0]   end_addr_s;

  logic                  word_ready_r;
  logic                  mem_we_r;
  logic [ADDR_WIDTH-1:0] mem_addr_r;
  logic [7:0]            mem_wdata_r;
  logic                  busy_r;
  logic                  done_r;

  // Extra bit keeps the bound check from wrapping near the top of the address space.
  assign end_addr_s = {1'b0, ptr_r} + (ADDR_WIDTH+1)'(3);

  // Next-state, pointer, byte-counter and word-latch logic.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    bc_s    = bc_r;
    word_s  = word_r;
    last_s  = last_r;
    err_s   = err_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_s = ST_ACCEPT;
          ptr_s   = BASE_PTR;
          bc_s    = 2'd0;
          err_s   = 1'b0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACCEPT: begin
        if (bus.word_valid) begin
          word_s = bus.word_in;
          last_s = bus.word_last;
          bc_s   = 2'd0;
          if (end_addr_s > LAST_BYTE) begin
            err_s   = 1'b1;
            state_s = ST_DONE;
          end else begin
            state_s = ST_WRITE;
          end
        end else begin
          state_s = ST_ACCEPT;
        end
      end
      ST_WRITE: begin
        if (bc_r == 2'd3) begin
          bc_s    = 2'd0;
          ptr_s   = ptr_r + ADDR_WIDTH'(4);
          state_s = last_r ? ST_DONE : ST_ACCEPT;
        end else begin
          bc_s = bc_r + 2'd1;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; outputs are registered from the next-state values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      ptr_r        <= BASE_PTR;
      bc_r         <= 2'd0;
      word_r       <= 32'h0000_0000;
      last_r       <= 1'b0;
      err_r        <= 1'b0;
      word_ready_r <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= {ADDR_WIDTH{1'b0}};
      mem_wdata_r  <= 8'h00;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      ptr_r        <= ptr_s;
      bc_r         <= bc_s;
      word_r       <= word_s;
      last_r       <= last_s;
      err_r        <= err_s;
      word_ready_r <= (state_s == ST_ACCEPT);
      mem_we_r     <= (state_s == ST_WRITE);
      mem_addr_r   <= (state_s == ST_WRITE) ? (ptr_s + ADDR_WIDTH'(bc_s)) : {ADDR_WIDTH{1'b0}};
      mem_wdata_r  <= (state_s == ST_WRITE) ? byte_sel(word_s, bc_s) : 8'h00;
      busy_r       <= (state_s != ST_IDLE);
      done_r       <= (state_s == ST_DONE);
    end
  end

  assign bus.word_ready = word_ready_r;
  assign bus.mem_we     = mem_we_r;
  assign bus.mem_addr   = mem_addr_r;
  assign bus.mem_wdata  = mem_wdata_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.err        = err_r;

`ifdef INST_MEM_LOADER_CHECKSUM_EN
  logic [7:0] checksum_r, checksum_s;

  // Sum the byte currently on the write port; mem_wdata_r is valid whenever state is WRITE.
  always_comb begin
    checksum_s = checksum_r;
    if ((state_r == ST_IDLE) && bus.start) begin
      checksum_s = 8'h00;
    end else if (state_r == ST_WRITE) begin
      checksum_s = checksum_r + mem_wdata_r;
    end else begin
      checksum_s = checksum_r;
    end
  end

  // Checksum register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      checksum_r <= 8'h00;
    end else begin
      checksum_r <= checksum_s;
    end
  end

  assign bus.checksum = checksum_r;
`endif

endmodule

// File: tb/tb_inst_mem_loader.sv
// Scoreboard bench for inst_mem_loader: a session-level model queues the expected byte
// writes and done events; a negedge monitor pops and compares them.
module tb_inst_mem_loader;
  localparam int AW    = 8;
  localparam int DEPTH = 32;
  localparam int BASE  = 0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  inst_mem_loader_if #(.ADDR_WIDTH(AW)) bus();

  inst_mem_loader #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;

  logic [15:0] wq[$];
  logic [8:0]  dq[$];
  logic [15:0] mon_w;
  logic [8:0]  mon_d;
  int          model_ptr;
  logic [7:0]  model_chk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && mon_en) begin
      if (bus.mem_we) begin
        if (wq.size() == 0) begin
          chk("unexpected_write_addr", {24'h0, bus.mem_addr}, 32'hFFFF_FFFF);
        end else begin
          mon_w = wq.pop_front();
          chk("wr_addr", {24'h0, bus.mem_addr}, {24'h0, mon_w[15:8]});
          chk("wr_data", {24'h0, bus.mem_wdata}, {24'h0, mon_w[7:0]});
        end
      end
      if (bus.done) begin
        if (dq.size() == 0) begin
          chk("unexpected_done", 32'h1, {31'h0, bus.mem_we});
        end else begin
          mon_d = dq.pop_front();
          chk("done_err", {31'h0, bus.err}, {31'h0, mon_d[8]});
          chk("done_no_write", {31'h0, bus.mem_we}, 32'h0);
`ifdef INST_MEM_LOADER_CHECKSUM_EN
          chk("done_checksum", {24'h0, bus.checksum}, {24'h0, mon_d[7:0]});
`endif
        end
      end
    end
  end

  // Reference model: a session writes words at BASE, BASE+4, ...; a word that would pass
  // the last byte is dropped and ends the session with err.
  task automatic model_word(input logic [31:0] w, input logic last, output bit ovf);
    logic [7:0] b;
    if (model_ptr + 3 > DEPTH - 1) begin
      ovf = 1'b1;
      dq.push_back({1'b1, model_chk});
    end else begin
      ovf = 1'b0;
      for (int i = 0; i < 4; i++) begin
        b = w[8*i +: 8];
        wq.push_back({8'(model_ptr + i), b});
        model_chk = model_chk + b;
      end
      model_ptr = model_ptr + 4;
      if (last) dq.push_back({1'b0, model_chk});
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    bus.start = 1'b1;
    model_ptr = BASE;
    model_chk = 8'h00;
    @(negedge clk);
    bus.start = 1'b0;
    chk("ready_after_start", {31'h0, bus.word_ready}, 32'h1);
    chk("err_cleared", {31'h0, bus.err}, 32'h0);
    chk("busy_after_start", {31'h0, bus.busy}, 32'h1);
  endtask

  task automatic send_word(input logic [31:0] w, input logic last, input int delay,
                           output int acc, output bit ovf);
    int n = 0;
    acc = cyc;
    ovf = 1'b0;
    @(negedge clk);
    if (delay == 0) begin
      bus.word_in = w; bus.word_last = last; bus.word_valid = 1'b1;
    end else begin
      bus.word_valid = 1'b0;
    end
    while (!bus.word_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", {31'h0, bus.word_ready}, 32'h1);
    if (!bus.word_ready) return;
    if (delay > 0) begin
      repeat (delay) @(negedge clk);
      chk("ready_held", {31'h0, bus.word_ready}, 32'h1);
      chk("no_write_before_accept", {31'h0, bus.mem_we}, 32'h0);
      bus.word_in = w; bus.word_last = last; bus.word_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    acc = cyc;
    model_word(w, last, ovf);
  endtask

  task automatic wait_done(input int acc, input int lat);
    int n = 0;
    bus.word_valid = 1'b0;
    @(negedge clk);
    while (!bus.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", {31'h0, bus.done}, 32'h1);
    chk("done_latency", cyc - acc, lat);
    chk("busy_in_done", {31'h0, bus.busy}, 32'h1);
    @(negedge clk);
    chk("busy_after_done", {31'h0, bus.busy}, 32'h0);
    chk("done_one_cycle", {31'h0, bus.done}, 32'h0);
  endtask

  task automatic session(input int n, input int dmax, input bit start_mid,
                         input bit fixed, input logic [31:0] w0, input logic [31:0] w1);
    int acc, prev, d;
    bit ovf;
    logic [31:0] w;
    prev = 0;
    do_start();
    for (int i = 0; i < n; i++) begin
      w = fixed ? ((i == 0) ? w0 : w1) : $urandom;
      d = (dmax == 0) ? 0 : $urandom_range(dmax, 0);
      send_word(w, (i == n - 1), d, acc, ovf);
      if (d == 0 && i > 0) chk("throughput", acc - prev, 5);
      prev = acc;
      if (start_mid && i == 0 && n > 1) begin
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
      end
    end
    wait_done(acc, 4);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int acc;
    bit ovf;
    bus.start = 1'b0; bus.word_in = 32'h0; bus.word_valid = 1'b0; bus.word_last = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'h0, bus.word_ready}, 32'h0);
    chk("rst_we", {31'h0, bus.mem_we}, 32'h0);
    chk("rst_addr", {24'h0, bus.mem_addr}, 32'h0);
    chk("rst_busy_done_err", {29'h0, bus.busy, bus.done, bus.err}, 32'h0);
    rst = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("idle_ready", {31'h0, bus.word_ready}, 32'h0);

    // Single word, then three words back-to-back, then backpressure.
    session(1, 0, 1'b0, 1'b1, 32'h0050_0093, 32'h0);
    session(3, 0, 1'b0, 1'b0, 32'h0, 32'h0);
    session(2, 3, 1'b1, 1'b0, 32'h0, 32'h0);
    session(2, 0, 1'b0, 1'b1, 32'h0102_0304, 32'hFFFF_FFFF);

    // Overflow: eight words fill memory, the ninth is dropped.
    do_start();
    for (int i = 0; i < 8; i++) send_word($urandom, 1'b0, 0, acc, ovf);
    send_word(32'hDEAD_BEEF, 1'b0, 0, acc, ovf);
    wait_done(acc, 0);
    chk("err_sticky", {31'h0, bus.err}, 32'h1);
    session(1, 0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Reset in the middle of a word.
    do_start();
    send_word(32'hA1B2_C3D4, 1'b1, 0, acc, ovf);
    bus.word_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #2;
    chk("we_before_reset", {31'h0, bus.mem_we}, 32'h1);
    rst = 1'b0;
    wq.delete();
    dq.delete();
    #1;
    chk("reset_we_drop", {31'h0, bus.mem_we}, 32'h0);
    chk("reset_addr_data", {16'h0, bus.mem_addr, bus.mem_wdata}, 32'h0);
    chk("reset_flags", {28'h0, bus.word_ready, bus.busy, bus.done, bus.err}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_reset_idle", {30'h0, bus.busy, bus.mem_we}, 32'h0);
    session(2, 1, 1'b0, 1'b0, 32'h0, 32'h0);

    for (int s = 0; s < 6; s++) begin
      session($urandom_range(5, 1), 3, $urandom_range(1, 0) == 1, 1'b0, 32'h0, 32'h0);
    end

    repeat (3) @(negedge clk);
    chk("write_queue_empty", wq.size(), 0);
    chk("done_queue_empty", dq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
